// File: rtl/stego_pkg.sv
// Shared types and helpers for the LSB steganography core.
package stego_pkg;

  typedef enum logic {
    EMBED   = 1'b0,
    EXTRACT = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of message bits carried by one pixel.
  function automatic int bits_per_pix(input int num_ch, input int bpc);
    return num_ch * bpc;
  endfunction

endpackage

// File: rtl/stego_msg_fifo.sv
// Byte FIFO holding message data for embedding; read data is available
// combinationally so a pop can be consumed in the same cycle.
module stego_msg_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       HRESETn,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic       full,
  output logic       empty,
  output logic [7:0] dout
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [AW:0]   count_next;
  logic          full_reg;
  logic          do_push;
  logic          do_pop;

  // A push while full is dropped even when a pop frees a slot this cycle.
  assign do_push = push && !full_reg;
  assign do_pop  = pop && (count_reg != '0);

  always_comb begin
    count_next = count_reg;
    if (do_push && !do_pop)
      count_next = count_reg + 1'b1;
    else if (do_pop && !do_push)
      count_next = count_reg - 1'b1;
  end

  always_ff @(posedge clk or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
    end else begin
      if (do_push)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
      full_reg  <= (count_next == (AW+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr_reg] <= din;
  end

  assign dout  = mem[rd_ptr_reg];
  assign full  = full_reg;
  assign empty = (count_reg == '0);

endmodule

// File: rtl/lsb_stego_core.sv
// Streaming LSB embedder/extractor: hides message bits in the low BPC bits of
// each colour channel, or recovers them, with valid/ready on both pixel ports.
module lsb_stego_core
  import stego_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int NUM_CH    = 3,
  parameter int BPC       = 1,
  parameter int MSG_DEPTH = 16,
  parameter int LEN_W     = 16
) (
  input  logic                     clk,
  input  logic                     HRESETn,
  input  logic                     start,
  input  logic                     mode,
  input  logic [LEN_W-1:0]         msg_len,
  input  logic [7:0]               msg_in,
  input  logic                     msg_in_valid,
  output logic                     msg_full,
  input  logic [NUM_CH*DATA_W-1:0] pix_in,
  input  logic                     pix_in_valid,
  output logic                     pix_in_ready,
  output logic [NUM_CH*DATA_W-1:0] pix_out,
  output logic                     pix_out_valid,
  input  logic                     pix_out_ready,
  output logic [7:0]               msg_out,
  output logic                     msg_out_valid,
  output logic                     busy,
  output logic                     done
);
  localparam int PIX_W = NUM_CH * DATA_W;
  localparam int NB    = bits_per_pix(NUM_CH, BPC);
  localparam int BL_W  = LEN_W + 3;
  localparam int PI_W  = $clog2(PIX_W);

  state_e            state_reg;
  mode_e             mode_reg;
  logic [BL_W-1:0]   bits_left_reg;
  logic [15:0]       buf_reg;
  logic [4:0]        cnt_reg;
  logic [7:0]        asm_reg;
  logic [2:0]        asm_cnt_reg;
  logic [PIX_W-1:0]  pix_out_reg;
  logic              pix_out_valid_reg;
  logic [7:0]        msg_out_reg;
  logic              msg_out_valid_reg;
  logic              busy_reg;
  logic              done_reg;

  logic              fifo_empty;
  logic              fifo_pop;
  logic [7:0]        fifo_dout;
  logic              run_embed;
  logic              run_extract;
  logic [BL_W-1:0]   take_w;
  logic [3:0]        take;
  logic [15:0]       eff_buf;
  logic [4:0]        eff_cnt;
  logic              can_go;
  logic              accept;
  logic [PIX_W-1:0]  pix_mod;
  logic [7:0]        asm_next;
  logic [2:0]        asm_cnt_next;
  logic              byte_done;
  logic [7:0]        byte_val;
  logic [PI_W-1:0]   bit_pos [NB];

  // Message bit j lands in channel j/BPC, earliest bit at the top of the field.
  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_pos
      assign bit_pos[gi] = PI_W'((gi / BPC) * DATA_W + (BPC - 1 - (gi % BPC)));
    end
  endgenerate

  stego_msg_fifo #(.DEPTH(MSG_DEPTH)) u_fifo (
    .clk    (clk),
    .HRESETn(HRESETn),
    .push   (msg_in_valid),
    .pop    (fifo_pop),
    .din    (msg_in),
    .full   (msg_full),
    .empty  (fifo_empty),
    .dout   (fifo_dout)
  );

  assign run_embed   = (state_reg == RUN) && (mode_reg == EMBED);
  assign run_extract = (state_reg == RUN) && (mode_reg == EXTRACT);
  assign take_w      = (bits_left_reg < BL_W'(NB)) ? bits_left_reg : BL_W'(NB);
  assign take        = take_w[3:0];

  // Refill the bit buffer one byte at a time; popped bits are usable at once.
  assign fifo_pop = run_embed && (cnt_reg < 5'(NB)) &&
                    (bits_left_reg > BL_W'(cnt_reg)) && !fifo_empty;
  assign eff_buf  = fifo_pop ? {buf_reg[7:0], fifo_dout} : buf_reg;
  assign eff_cnt  = fifo_pop ? cnt_reg + 5'd8 : cnt_reg;

  assign can_go       = !(run_embed && (BL_W'(cnt_reg) < take_w) && fifo_empty);
  assign pix_in_ready = HRESETn && (!pix_out_valid_reg || pix_out_ready) && can_go;
  assign accept       = pix_in_valid && pix_in_ready;

  always_comb begin
    pix_mod      = pix_in;
    asm_next     = asm_reg;
    asm_cnt_next = asm_cnt_reg;
    byte_done    = 1'b0;
    byte_val     = asm_reg;
    for (int j = 0; j < NB; j++) begin
      if (4'(j) < take) begin
        if (run_embed)
          pix_mod[bit_pos[j]] = eff_buf[4'(eff_cnt - 5'd1 - 5'(j))];
        if (run_extract) begin
          asm_next = {asm_next[6:0], pix_in[bit_pos[j]]};
          if (asm_cnt_next == 3'd7) begin
            byte_done    = 1'b1;
            byte_val     = asm_next;
            asm_cnt_next = 3'd0;
          end else begin
            asm_cnt_next = asm_cnt_next + 3'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge HRESETn) begin
    if (!HRESETn) begin
      state_reg         <= IDLE;
      mode_reg          <= EMBED;
      bits_left_reg     <= '0;
      buf_reg           <= '0;
      cnt_reg           <= '0;
      asm_reg           <= '0;
      asm_cnt_reg       <= '0;
      pix_out_reg       <= '0;
      pix_out_valid_reg <= 1'b0;
      msg_out_reg       <= '0;
      msg_out_valid_reg <= 1'b0;
      busy_reg          <= 1'b0;
      done_reg          <= 1'b0;
    end else begin
      msg_out_valid_reg <= 1'b0;
      if (accept) begin
        pix_out_reg       <= pix_mod;
        pix_out_valid_reg <= 1'b1;
      end else if (pix_out_ready) begin
        pix_out_valid_reg <= 1'b0;
      end

      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            mode_reg      <= mode_e'(mode);
            bits_left_reg <= {msg_len, 3'b000};
            buf_reg       <= '0;
            cnt_reg       <= '0;
            asm_reg       <= '0;
            asm_cnt_reg   <= '0;
            if (msg_len == '0) begin
              state_reg <= DONE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= RUN;
              busy_reg  <= 1'b1;
              done_reg  <= 1'b0;
            end
          end
        end
        RUN: begin
          buf_reg <= eff_buf;
          if (accept) begin
            cnt_reg       <= eff_cnt - 5'(take);
            bits_left_reg <= bits_left_reg - take_w;
            asm_reg       <= asm_next;
            asm_cnt_reg   <= asm_cnt_next;
            if (byte_done) begin
              msg_out_reg       <= byte_val;
              msg_out_valid_reg <= 1'b1;
            end
            if (bits_left_reg == take_w) begin
              state_reg <= DONE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end
          end else begin
            cnt_reg <= eff_cnt;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign pix_out       = pix_out_reg;
  assign pix_out_valid = pix_out_valid_reg;
  assign msg_out       = msg_out_reg;
  assign msg_out_valid = msg_out_valid_reg;
  assign busy          = busy_reg;
  assign done          = done_reg;

endmodule
